// File: rtl/tlul_host_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tlul_host_arb
//  Description : Shares one in-order TL-UL device port between several TL-UL
//                hosts. The A channel is arbitrated round-robin, with a grant
//                lock that holds under device backpressure. The host index of
//                every accepted request goes into an in-order tracking FIFO,
//                and each D response is routed to the host at the FIFO head.
//                A/D payloads, including user/integrity bits, pass through
//                unmodified.
//  Revision    : 1.0 - initial release
// ============================================================================

package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_host_arb
    import tlul_pkg::*;
#(
    parameter  int NumHosts       = 2,
    parameter  int MaxOutstanding = 4,
    localparam int HostW          = $clog2(NumHosts),
    localparam int CntW           = $clog2(MaxOutstanding) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h_i [NumHosts],
    output tl_d2h_t         tl_h_o [NumHosts],
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            rsp_err_o
);

    localparam int              PtrW    = $clog2(MaxOutstanding);
    localparam logic [CntW-1:0] c_depth = CntW'(MaxOutstanding);

    // Arbitration state
    logic [HostW-1:0] r_rr_ptr;
    logic             r_lock;
    logic [HostW-1:0] r_lock_idx;

    // Tracking FIFO: host index of every request still awaiting a response
    logic [HostW-1:0] r_fifo [MaxOutstanding];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             r_rsp_err;

    logic [HostW-1:0] w_winner;
    logic [HostW-1:0] w_cand;
    logic             w_found;
    logic [HostW-1:0] w_grant;
    logic [HostW-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_a_valid;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // Round-robin search starting just after the last granted host
    always_comb begin
        w_winner = '0;
        w_cand   = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= NumHosts; k++) begin
            w_cand = HostW'((int'(r_rr_ptr) + k) % NumHosts);
            if (!w_found && tl_h_i[w_cand].a_valid) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Device-side A mux; a full FIFO blocks A independently of any pop so
    // that no combinational path runs from d_valid to a_ready
    always_comb begin
        w_grant   = r_lock ? r_lock_idx : w_winner;
        w_a_valid = tl_h_i[w_grant].a_valid & ~w_full;
        tl_d_o          = tl_h_i[w_grant];
        tl_d_o.a_valid  = w_a_valid;
        // With nothing in flight a response is spurious: sink it
        tl_d_o.d_ready  = w_empty ? 1'b1 : tl_h_i[w_head].d_ready;
    end

    assign w_push = w_a_valid & tl_d_i.a_ready;
    assign w_pop  = tl_d_i.d_valid & ~w_empty & tl_h_i[w_head].d_ready;

    // Host-side responses: D payload broadcast, valid only to the FIFO head
    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].a_ready = (w_grant == HostW'(i)) & tl_d_i.a_ready & ~w_full;
            tl_h_o[i].d_valid = tl_d_i.d_valid & ~w_empty & (w_head == HostW'(i));
        end
    end

    // Round-robin pointer and grant lock held while the device stalls A
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_push) begin
            r_rr_ptr <= w_grant;
            r_lock   <= 1'b0;
        end else if (w_a_valid && !tl_d_i.a_ready) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
        end
    end

    // Tracking FIFO storage (contents are only meaningful below r_count)
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_grant;
        end
    end

    // Tracking FIFO pointers and occupancy; reset discards in-flight tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    // One-cycle flag for a response arriving with nothing outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= tl_d_i.d_valid & w_empty;
        end
    end

    assign outstanding_o = r_count;
    assign rsp_err_o     = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_tlul_host_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlul_host_arb
//  Description : Self-checking bench for tlul_host_arb: directed scenarios
//                followed by randomized traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int NH = 2;
    localparam int MO = 4;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    tl_h2d_t  h_req [NH];
    tl_d2h_t  h_rsp [NH];
    tl_h2d_t  d_req;
    tl_d2h_t  d_rsp;
    logic [2:0] outstanding;
    logic       rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlul_host_arb #(.NumHosts(NH), .MaxOutstanding(MO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tl_h_i       (h_req),
        .tl_h_o       (h_rsp),
        .tl_d_o       (d_req),
        .tl_d_i       (d_rsp),
        .outstanding_o(outstanding),
        .rsp_err_o    (rsp_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        for (int i = 0; i < NH; i++) begin
            h_req[i]          = '0;
            h_req[i].a_source = 8'(i);
            h_req[i].a_opcode = 3'd4;
            h_req[i].d_ready  = 1'b1;
        end
        d_rsp = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        checks++; if (d_req.a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", d_req.a_valid); end
        for (int i = 0; i < NH; i++) begin
            checks++; if (h_rsp[i].d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid[%0d]: got %b expected 0", i, h_rsp[i].d_valid); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read;
        tick();
        h_req[0].a_valid   = 1'b1;
        h_req[0].a_address = 32'h10;
        d_rsp.a_ready      = 1'b1;
        #1;
        checks++; if (d_req.a_valid !== 1'b1) begin errors++; $display("FAIL single_a_valid: got %b expected 1", d_req.a_valid); end
        checks++; if (d_req.a_address !== 32'h10) begin errors++; $display("FAIL single_addr: got %0h expected 10", d_req.a_address); end
        checks++; if (h_rsp[0].a_ready !== 1'b1 || h_rsp[1].a_ready !== 1'b0) begin errors++; $display("FAIL single_a_ready: got %b%b expected 01", h_rsp[1].a_ready, h_rsp[0].a_ready); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_out0: got %0d expected 0", outstanding); end
        tick();
        h_req[0].a_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_out1: got %0d expected 1", outstanding); end
        tick();
        d_rsp.d_valid  = 1'b1;
        d_rsp.d_opcode = 3'd1;
        d_rsp.d_data   = 32'hDEADBEEF;
        #1;
        checks++; if (h_rsp[0].d_valid !== 1'b1) begin errors++; $display("FAIL single_h0_d_valid: got %b expected 1", h_rsp[0].d_valid); end
        checks++; if (h_rsp[0].d_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_d_data: got %0h expected deadbeef", h_rsp[0].d_data); end
        checks++; if (h_rsp[1].d_valid !== 1'b0) begin errors++; $display("FAIL single_h1_d_valid: got %b expected 0", h_rsp[1].d_valid); end
        checks++; if (d_req.d_ready !== 1'b1) begin errors++; $display("FAIL single_d_ready: got %b expected 1", d_req.d_ready); end
        tick();
        d_rsp.d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_out_end: got %0d expected 0", outstanding); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b expected 0", rsp_err); end
    endtask

    task automatic test_contention;
        int prev = 0;
        int exp_g;
        for (int c = 0; c < 6; c++) begin
            tick();
            h_req[0].a_valid = 1'b1;
            h_req[1].a_valid = 1'b1;
            d_rsp.d_valid    = (c > 0);
            d_rsp.d_data     = 32'h100 + 32'(c);
            #1;
            exp_g = (c % 2 == 0) ? 1 : 0;
            checks++; if (h_rsp[exp_g].a_ready !== 1'b1 || h_rsp[1-exp_g].a_ready !== 1'b0) begin errors++; $display("FAIL contention_grant c=%0d: got a_ready=%b%b expected host %0d", c, h_rsp[1].a_ready, h_rsp[0].a_ready, exp_g); end
            checks++; if (d_req.a_source !== 8'(exp_g)) begin errors++; $display("FAIL contention_source c=%0d: got %0d expected %0d", c, d_req.a_source, exp_g); end
            if (c > 0) begin
                checks++; if (h_rsp[prev].d_valid !== 1'b1 || h_rsp[1-prev].d_valid !== 1'b0) begin errors++; $display("FAIL contention_rsp c=%0d: got d_valid=%b%b expected host %0d", c, h_rsp[1].d_valid, h_rsp[0].d_valid, prev); end
            end
            prev = exp_g;
        end
        tick();
        h_req[0].a_valid = 1'b0;
        h_req[1].a_valid = 1'b0;
        d_rsp.d_valid    = 1'b1;
        #1;
        checks++; if (h_rsp[prev].d_valid !== 1'b1 || h_rsp[1-prev].d_valid !== 1'b0) begin errors++; $display("FAIL contention_last_rsp: got d_valid=%b%b expected host %0d", h_rsp[1].d_valid, h_rsp[0].d_valid, prev); end
        tick();
        d_rsp.d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL contention_out: got %0d expected 0", outstanding); end
    endtask

    task automatic test_lock;
        tick();
        h_req[0].a_valid   = 1'b1;
        h_req[0].a_address = 32'hA0;
        d_rsp.a_ready      = 1'b0;
        #1;
        checks++; if (d_req.a_valid !== 1'b1 || d_req.a_address !== 32'hA0) begin errors++; $display("FAIL lock_first: got v=%b addr=%0h expected v=1 addr=a0", d_req.a_valid, d_req.a_address); end
        for (int c = 1; c < 3; c++) begin
            tick();
            h_req[1].a_valid   = 1'b1;
            h_req[1].a_address = 32'hB0;
            #1;
            checks++; if (d_req.a_address !== 32'hA0 || d_req.a_source !== 8'd0) begin errors++; $display("FAIL lock_hold c=%0d: got addr=%0h src=%0d expected a0/0", c, d_req.a_address, d_req.a_source); end
        end
        tick();
        d_rsp.a_ready = 1'b1;
        #1;
        checks++; if (d_req.a_address !== 32'hA0 || h_rsp[0].a_ready !== 1'b1 || h_rsp[1].a_ready !== 1'b0) begin errors++; $display("FAIL lock_accept0: got addr=%0h rdy=%b%b expected a0 rdy=01", d_req.a_address, h_rsp[1].a_ready, h_rsp[0].a_ready); end
        tick();
        h_req[0].a_valid = 1'b0;
        #1;
        checks++; if (d_req.a_address !== 32'hB0 || h_rsp[1].a_ready !== 1'b1) begin errors++; $display("FAIL lock_accept1: got addr=%0h rdy1=%b expected b0 rdy1=1", d_req.a_address, h_rsp[1].a_ready); end
        tick();
        h_req[1].a_valid = 1'b0;
        d_rsp.d_valid    = 1'b1;
        #1;
        checks++; if (h_rsp[0].d_valid !== 1'b1 || h_rsp[1].d_valid !== 1'b0) begin errors++; $display("FAIL lock_rsp0: got d_valid=%b%b expected 01", h_rsp[1].d_valid, h_rsp[0].d_valid); end
        tick();
        #1;
        checks++; if (h_rsp[1].d_valid !== 1'b1 || h_rsp[0].d_valid !== 1'b0) begin errors++; $display("FAIL lock_rsp1: got d_valid=%b%b expected 10", h_rsp[1].d_valid, h_rsp[0].d_valid); end
        tick();
        d_rsp.d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL lock_out: got %0d expected 0", outstanding); end
    endtask

    task automatic test_full;
        for (int c = 0; c < 4; c++) begin
            tick();
            h_req[0].a_valid   = 1'b1;
            h_req[0].a_address = 32'h200 + 32'(c);
            #1;
            checks++; if (h_rsp[0].a_ready !== 1'b1) begin errors++; $display("FAIL full_fill c=%0d: got a_ready=%b expected 1", c, h_rsp[0].a_ready); end
        end
        tick();
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_out4: got %0d expected 4", outstanding); end
        checks++; if (d_req.a_valid !== 1'b0 || h_rsp[0].a_ready !== 1'b0) begin errors++; $display("FAIL full_block: got v=%b rdy=%b expected 0/0", d_req.a_valid, h_rsp[0].a_ready); end
        tick();
        d_rsp.d_valid = 1'b1;
        #1;
        checks++; if (d_req.a_valid !== 1'b0 || h_rsp[0].d_valid !== 1'b1) begin errors++; $display("FAIL full_pop_cycle: got a_valid=%b d_valid=%b expected 0/1", d_req.a_valid, h_rsp[0].d_valid); end
        tick();
        d_rsp.d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_out3: got %0d expected 3", outstanding); end
        checks++; if (d_req.a_valid !== 1'b1 || h_rsp[0].a_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got v=%b rdy=%b expected 1/1", d_req.a_valid, h_rsp[0].a_ready); end
        tick();
        h_req[0].a_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d expected 4", outstanding); end
    endtask

    task automatic test_rsp_backpressure;
        for (int c = 0; c < 2; c++) begin
            tick();
            h_req[0].d_ready = 1'b0;
            d_rsp.d_valid    = 1'b1;
            #1;
            checks++; if (d_req.d_ready !== 1'b0) begin errors++; $display("FAIL bp_d_ready c=%0d: got %b expected 0", c, d_req.d_ready); end
            checks++; if (h_rsp[0].d_valid !== 1'b1 || h_rsp[1].d_valid !== 1'b0) begin errors++; $display("FAIL bp_d_valid c=%0d: got %b%b expected 01", c, h_rsp[1].d_valid, h_rsp[0].d_valid); end
            checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL bp_out c=%0d: got %0d expected 4", c, outstanding); end
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            h_req[0].d_ready = 1'b1;
            #1;
            checks++; if (h_rsp[0].d_valid !== 1'b1 || d_req.d_ready !== 1'b1) begin errors++; $display("FAIL bp_drain c=%0d: got d_valid=%b d_ready=%b expected 1/1", c, h_rsp[0].d_valid, d_req.d_ready); end
        end
        tick();
        d_rsp.d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL bp_out_end: got %0d expected 0", outstanding); end
    endtask

    task automatic test_spurious;
        tick();
        h_req[0].d_ready = 1'b0;
        h_req[1].d_ready = 1'b0;
        d_rsp.d_valid    = 1'b1;
        #1;
        checks++; if (d_req.d_ready !== 1'b1) begin errors++; $display("FAIL spur_d_ready: got %b expected 1", d_req.d_ready); end
        checks++; if (h_rsp[0].d_valid !== 1'b0 || h_rsp[1].d_valid !== 1'b0) begin errors++; $display("FAIL spur_d_valid: got %b%b expected 00", h_rsp[1].d_valid, h_rsp[0].d_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL spur_err_early: got %b expected 0", rsp_err); end
        tick();
        d_rsp.d_valid    = 1'b0;
        h_req[0].d_ready = 1'b1;
        h_req[1].d_ready = 1'b1;
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL spur_err_pulse: got %b expected 1", rsp_err); end
        tick();
        #1;
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL spur_err_clear: got %b expected 0", rsp_err); end
    endtask

    task automatic test_reset_mid;
        tick();
        h_req[0].a_valid = 1'b1;
        d_rsp.a_ready    = 1'b1;
        tick();
        tick();
        h_req[0].a_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL rstmid_out2: got %0d expected 2", outstanding); end
        rst_n = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rstmid_out0: got %0d expected 0", outstanding); end
        tick();
        rst_n = 1'b1;
        tick();
        d_rsp.d_valid = 1'b1;
        #1;
        checks++; if (d_req.d_ready !== 1'b1 || h_rsp[0].d_valid !== 1'b0) begin errors++; $display("FAIL rstmid_sink: got d_ready=%b h0_d_valid=%b expected 1/0", d_req.d_ready, h_rsp[0].d_valid); end
        tick();
        d_rsp.d_valid = 1'b0;
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL rstmid_err: got %b expected 1", rsp_err); end
    endtask

    // Model: queue of hosts awaiting responses, last-granted host, lock owner
    task automatic test_random;
        int          q[$];
        logic        pend [NH];
        logic [31:0] addr [NH];
        int          m_last = 0;
        bit          m_lock = 0;
        int          m_lock_h = 0;
        int          g;
        int          idx;
        bit          found, exp_av, acc, pop, exp_bit;
        for (int i = 0; i < NH; i++) begin
            pend[i] = 1'b0;
            addr[i] = '0;
        end
        tick();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NH; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    addr[i] = $urandom;
                end
                h_req[i].a_valid   = pend[i];
                h_req[i].a_address = addr[i];
                h_req[i].d_ready   = ($urandom_range(0, 3) != 0);
            end
            d_rsp.a_ready = ($urandom_range(0, 2) != 0);
            d_rsp.d_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            d_rsp.d_data  = $urandom;
            #1;
            if (m_lock) begin
                g = m_lock_h;
            end else begin
                g = 0;
                found = 0;
                for (int k = 1; k <= NH; k++) begin
                    idx = (m_last + k) % NH;
                    if (!found && pend[idx]) begin
                        found = 1;
                        g = idx;
                    end
                end
            end
            exp_av = pend[g] && (q.size() < MO);
            checks++; if (d_req.a_valid !== exp_av) begin errors++; $display("FAIL rand_a_valid c=%0d: got %b expected %b", c, d_req.a_valid, exp_av); end
            if (exp_av) begin
                checks++; if (d_req.a_address !== addr[g]) begin errors++; $display("FAIL rand_addr c=%0d: got %0h expected %0h", c, d_req.a_address, addr[g]); end
            end
            for (int i = 0; i < NH; i++) begin
                exp_bit = (i == g) && d_rsp.a_ready && (q.size() < MO);
                checks++; if (h_rsp[i].a_ready !== exp_bit) begin errors++; $display("FAIL rand_a_ready[%0d] c=%0d: got %b expected %b", i, c, h_rsp[i].a_ready, exp_bit); end
                exp_bit = (q.size() > 0) && (q[0] == i) && d_rsp.d_valid;
                checks++; if (h_rsp[i].d_valid !== exp_bit) begin errors++; $display("FAIL rand_d_valid[%0d] c=%0d: got %b expected %b", i, c, h_rsp[i].d_valid, exp_bit); end
            end
            pop = 0;
            if (q.size() > 0) begin
                checks++; if (d_req.d_ready !== h_req[q[0]].d_ready) begin errors++; $display("FAIL rand_d_ready c=%0d: got %b expected %b", c, d_req.d_ready, h_req[q[0]].d_ready); end
                if (d_rsp.d_valid) begin
                    checks++; if (h_rsp[q[0]].d_data !== d_rsp.d_data) begin errors++; $display("FAIL rand_d_data c=%0d: got %0h expected %0h", c, h_rsp[q[0]].d_data, d_rsp.d_data); end
                end
                pop = d_rsp.d_valid && h_req[q[0]].d_ready;
            end
            acc = exp_av && d_rsp.a_ready;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(g);
                m_last  = g;
                m_lock  = 0;
                pend[g] = 1'b0;
            end else if (exp_av) begin
                m_lock   = 1;
                m_lock_h = g;
            end
            tick();
            checks++; if (outstanding !== 3'(q.size())) begin errors++; $display("FAIL rand_outstanding c=%0d: got %0d expected %0d", c, outstanding, q.size()); end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_full();
        test_rsp_backpressure();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
